// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin arbiter serializing NUM_REQ hold-until-done ports onto one single-port BRAM,
// with a watchdog that aborts an access whose done never arrives.
module bram_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic [NUM_REQ-1:0]      req_read,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*32-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    output logic [31:0]             req_rdata,
    output logic [NUM_REQ-1:0]      req_done,
    output logic                    req_err,
    output logic [31:0]             bram_addr,
    output logic [31:0]             bram_wdata,
    output logic                    bram_read,
    output logic                    bram_write,
    input  logic [31:0]             bram_rdata,
    input  logic                    bram_done
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state_q;
    logic [IW-1:0]      ptr_q, gnt_q, gnt_d;
    logic               any_d, wr_q, err_q, rd_stb_q, wr_stb_q;
    logic [7:0]         cnt_q;
    logic [31:0]        rdata_q, addr_q, wdata_q;
    logic [NUM_REQ-1:0] pend, done_q;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v >= NUM_REQ ? v - NUM_REQ : v);
    endfunction

    assign pend = req_read | req_write;

    // Scanning from the far end down lets the closest pending index at or after ptr win.
    always_comb begin
        gnt_d = ptr_q;
        any_d = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pend[wrap(int'(ptr_q) + k)]) begin
                gnt_d = wrap(int'(ptr_q) + k);
                any_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            rdata_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (any_d) begin
                    gnt_q    <= gnt_d;
                    addr_q   <= req_addr[32*gnt_d +: 32];
                    wdata_q  <= req_wdata[32*gnt_d +: 32];
                    wr_q     <= ~req_read[gnt_d];
                    rd_stb_q <= req_read[gnt_d];
                    wr_stb_q <= ~req_read[gnt_d];
                    state_q  <= ISSUE;
                end
                ISSUE: begin
                    rd_stb_q <= 1'b0;
                    wr_stb_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (bram_done) begin
                        if (!wr_q) rdata_q <= bram_rdata;
                        done_q  <= NUM_REQ'(1) << gnt_q;
                        state_q <= DONE;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        done_q  <= NUM_REQ'(1) << gnt_q;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    done_q  <= '0;
                    err_q   <= 1'b0;
                    ptr_q   <= wrap(int'(gnt_q) + 1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_rdata  = rdata_q;
    assign req_done   = done_q;
    assign req_err    = err_q;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;
    assign bram_read  = rd_stb_q;
    assign bram_write = wr_stb_q;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: scoreboard bench; each requester works in its own 256-byte region so read data is
// predictable at issue time, and a monitor pops expectations on every req_done.
module tb_bram_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        bit          rd;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  res = 1'b1;
    logic [NUM_REQ-1:0]    req_read = '0, req_write = '0;
    logic [NUM_REQ*32-1:0] req_addr = '0, req_wdata = '0;
    logic [31:0]           req_rdata;
    logic [NUM_REQ-1:0]    req_done;
    logic                  req_err;
    logic [31:0]           bram_addr, bram_wdata;
    logic                  bram_read, bram_write;
    logic [31:0]           bram_rdata;
    logic                  bram_done;

    bit          suppress, inject;
    logic [31:0] mem [256];
    bit          vld [256];
    logic [31:0] ref_mem [256];
    exp_t        expq [NUM_REQ][$];
    int          done_log[$], done_cyc[$];
    int          checks, errors, cyc, rd_cnt, wr_cnt, st_cyc;
    logic [31:0] st_addr, last_rd;

    bram_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .res(res),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rdata(req_rdata), .req_done(req_done), .req_err(req_err),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_read(bram_read), .bram_write(bram_write),
        .bram_rdata(bram_rdata), .bram_done(bram_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int k);
        return k == 4 ? 32'hDEADBEEF : (32'h5A5A_0000 ^ (32'(k) * 32'h0101_0101));
    endfunction

    // BRAM device: answers one cycle after a strobe unless suppressed; inject forces stray dones.
    always @(posedge clk) begin
        bram_done <= inject;
        if (bram_read || bram_write) begin
            if (bram_write) begin
                mem[bram_addr[9:2]] <= bram_wdata;
                vld[bram_addr[9:2]] <= 1'b1;
            end
            bram_rdata <= suppress ? $urandom : (vld[bram_addr[9:2]] ? mem[bram_addr[9:2]] : init_word(int'(bram_addr[9:2])));
            if (!suppress) bram_done <= 1'b1;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic check_zero(input string n);
        chk({n, "_req_done"}, 32'(req_done), 0);
        chk({n, "_req_err"}, 32'(req_err), 0);
        chk({n, "_req_rdata"}, req_rdata, 0);
        chk({n, "_bram_addr"}, bram_addr, 0);
        chk({n, "_bram_wdata"}, bram_wdata, 0);
        chk({n, "_bram_read"}, 32'(bram_read), 0);
        chk({n, "_bram_write"}, 32'(bram_write), 0);
    endtask

    task automatic monitor();
        bit   prev;
        int   idx;
        exp_t e;
        forever begin
            @(negedge clk);
            if (res) begin
                for (int k = 0; k < NUM_REQ; k++) expq[k].delete();
                last_rd = '0;
                prev = 1'b0;
            end else begin
                if (bram_read || bram_write) begin
                    chk("strobe_exclusive", 32'(bram_read & bram_write), 0);
                    chk("strobe_one_cycle", 32'(prev), 0);
                    rd_cnt += int'(bram_read);
                    wr_cnt += int'(bram_write);
                    st_cyc = cyc;
                    st_addr = bram_addr;
                end
                prev = bram_read | bram_write;
                if (req_done != '0) begin
                    idx = 0;
                    for (int k = 0; k < NUM_REQ; k++) if (req_done[k]) idx = k;
                    done_log.push_back(idx);
                    done_cyc.push_back(cyc);
                    chk("done_onehot", 32'($onehot(req_done)), 1);
                    if (expq[idx].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: req_done=%b, expected no completion for requester %0d", req_done, idx);
                    end else begin
                        e = expq[idx].pop_front();
                        chk("req_err", 32'(req_err), 32'(e.err));
                        if (e.rd && !e.err) begin
                            chk("read_data", req_rdata, e.data);
                            last_rd = e.data;
                        end else begin
                            chk("rdata_hold", req_rdata, last_rd);
                        end
                    end
                end else begin
                    chk("err_without_done", 32'(req_err), 0);
                end
            end
        end
    endtask

    task automatic issue(input int i, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input bit err, output int t0, output int lat);
        exp_t e;
        @(posedge clk);
        #1;
        e.rd = rd;
        e.err = err;
        e.data = ref_mem[a[9:2]];
        if (wr && !rd) ref_mem[a[9:2]] = d;
        expq[i].push_back(e);
        req_read[i] = rd;
        req_write[i] = wr;
        req_addr[32*i +: 32] = a;
        req_wdata[32*i +: 32] = d;
        t0 = cyc;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_done[i]) begin
                lat = cyc - t0;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL done_wait_req%0d: no req_done within 100 cycles, expected one", i);
        end
        @(posedge clk);
        #1;
        req_read[i] = 1'b0;
        req_write[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 res = 1'b1;
        @(posedge clk);
        #1 res = 1'b0;
    endtask

    task automatic rr(input int i);
        int t0, lat;
        for (int n = 0; n < 2; n++) issue(i, 1'b1, 1'b0, 32'(i) * 32'h100 + 32'(8 * n), 32'h0, 1'b0, t0, lat);
    endtask

    task automatic rand_req(input int i);
        int          t0, lat, op;
        logic [31:0] a;
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            op = int'($urandom_range(0, 2));
            a = 32'(i) * 32'h100 + 32'($urandom_range(0, 255));
            issue(i, op != 1, op != 0, a, $urandom, 1'b0, t0, lat);
            chk("fair_latency", 32'(lat <= 4 * NUM_REQ - 1), 1);
        end
    endtask

    initial begin
        int t0, ta, tb, lat, la, lb, r0, w0;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 res = 1'b0;
        @(negedge clk);
        check_zero("reset");

        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, t0, lat);
        chk("single_latency", 32'(lat), 3);
        chk("single_strobe_cycle", 32'(st_cyc - t0), 1);
        chk("single_strobe_addr", st_addr, 32'h10);

        w0 = wr_cnt;
        issue(2, 1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0, t0, lat);
        chk("write_strobes", 32'(wr_cnt - w0), 1);
        issue(2, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, t0, lat);
        chk("readback", req_rdata, 32'h12345678);

        r0 = rd_cnt;
        w0 = wr_cnt;
        issue(1, 1'b1, 1'b1, 32'h30, 32'hFFFF_FFFF, 1'b0, t0, lat);
        chk("rw_read_strobes", 32'(rd_cnt - r0), 1);
        chk("rw_write_strobes", 32'(wr_cnt - w0), 0);

        suppress = 1'b1;
        issue(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, t0, lat);
        suppress = 1'b0;
        chk("timeout_latency", 32'(lat), TIMEOUT + 2);
        fork
            begin
                inject = 1'b1;
                repeat (2) @(posedge clk);
                #1 inject = 1'b0;
            end
            issue(1, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, t0, lat);
        join
        chk("post_timeout_latency", 32'(lat), 3);

        // Leave ptr at 2 so a reset that failed to clear it would favour requester 3 below.
        issue(1, 1'b1, 1'b0, 32'h50, 32'h0, 1'b0, t0, lat);
        @(posedge clk);
        #1 req_read[2] = 1'b1;
        req_addr[64 +: 32] = 32'h210;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        res = 1'b1;
        @(posedge clk);
        #1 res = 1'b0;
        req_read[2] = 1'b0;
        @(negedge clk);
        check_zero("mid_wait_reset");
        repeat (4) @(posedge clk);
        done_log.delete();
        done_cyc.delete();
        fork
            issue(3, 1'b1, 1'b0, 32'h310, 32'h0, 1'b0, ta, la);
            issue(0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, tb, lb);
        join
        chk("contention_count", 32'(done_log.size()), 2);
        if (done_log.size() >= 2) begin
            chk("contention_winner", 32'(done_log[0]), 0);
            chk("contention_second", 32'(done_log[1]), 3);
        end
        chk("contention_lat0", 32'(lb), 3);
        chk("contention_lat3", 32'(la), 7);

        do_reset();
        done_log.delete();
        done_cyc.delete();
        fork
            rr(0);
            rr(1);
            rr(2);
            rr(3);
        join
        chk("rr_count", 32'(done_log.size()), 8);
        for (int k = 0; k < 8; k++) if (k < done_log.size()) chk("rr_order", 32'(done_log[k]), 32'(k % 4));
        for (int k = 1; k < 8; k++) if (k < done_cyc.size()) chk("rr_spacing", 32'(done_cyc[k] - done_cyc[k-1]), 4);

        fork
            rand_req(0);
            rand_req(1);
            rand_req(2);
            rand_req(3);
        join
        repeat (3) @(posedge clk);
        for (int k = 0; k < NUM_REQ; k++) chk("queue_drained", 32'(expq[k].size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
